// File: rtl/fp_pack_if.sv
// Handshake bundle for fp_pack: operand request on the in_* side, packed float result on the out_* side.
// The master drives operands and out_ready; the slave (fp_pack) returns the result.
interface fp_pack_if #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23
);
    localparam int MW = MANTIS_SIZE + 4;
    localparam int EW = EXP_SIZE + 2;
    localparam int FW = EXP_SIZE + MANTIS_SIZE + 1;

    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [2:0]    in_type;
    logic [EW-1:0] in_exp;
    logic [MW-1:0] in_mantis;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_float;
    logic [2:0]    out_type;
    logic          out_inexact;
    logic          out_overflow;

    modport master (
        output in_valid, in_sign, in_type, in_exp, in_mantis, out_ready,
        input  in_ready, out_valid, out_float, out_type, out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_type, in_exp, in_mantis, out_ready,
        output in_ready, out_valid, out_float, out_type, out_inexact, out_overflow
    );
endinterface

// File: rtl/fp_pack.sv
// Packs sign/type/wide exponent/unnormalised mantissa into an IEEE-754-style float.
// Iterative normalise, denormalise and round-to-nearest-even; one operation in flight.
module fp_pack #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23
) (
    input  logic     clk,
    input  logic     rst,
    fp_pack_if.slave bus
);
    localparam int MW = MANTIS_SIZE + 4;
    localparam int EW = EXP_SIZE + 2;
    localparam int FW = EXP_SIZE + MANTIS_SIZE + 1;

    localparam logic signed [EW-1:0]    E_ONE     = EW'(1);
    localparam logic signed [EW-1:0]    E_MAX     = EW'((1 << EXP_SIZE) - 1);
    localparam logic [EXP_SIZE-1:0]     EXP_ONES  = '1;
    localparam logic [EXP_SIZE-1:0]     EXP_ZERO  = '0;
    localparam logic [MANTIS_SIZE-1:0]  FRAC_ZERO = '0;
    localparam logic [MANTIS_SIZE-1:0]  FRAC_QNAN = {1'b1, {(MANTIS_SIZE-1){1'b0}}};

    localparam logic [2:0] T_ZERO = 3'b000;
    localparam logic [2:0] T_INF  = 3'b001;
    localparam logic [2:0] T_SUB  = 3'b010;
    localparam logic [2:0] T_NORM = 3'b011;
    localparam logic [2:0] T_NAN  = 3'b100;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_DENORM, S_ROUND, S_DONE} state_t;

    state_t                 state_q;
    logic [MW-1:0]          m_q;
    logic signed [EW-1:0]   e_q;
    logic                   sign_q;
    logic                   out_valid_q;
    logic [FW-1:0]          out_float_q;
    logic [2:0]             out_type_q;
    logic                   out_inexact_q;
    logic                   out_overflow_q;

    logic [MW-1:0]          m_shr;
    logic signed [EW-1:0]   e_inc;
    logic signed [EW-1:0]   e_dec;
    logic                   round_up;
    logic [MW-3:0]          m_sum;
    logic                   r_carry;
    logic                   r_hidden;
    logic [MANTIS_SIZE-1:0] r_frac;
    logic signed [EW-1:0]   r_exp;

    // Right shift keeps everything shifted out folded into the sticky bit.
    always_comb begin
        m_shr    = m_q >> 1;
        m_shr[0] = m_q[1] | m_q[0];
        e_inc    = e_q + E_ONE;
        e_dec    = e_q - E_ONE;
        round_up = m_q[1] & (m_q[0] | m_q[2]);
        m_sum    = m_q[MW-1:2] + {{(MW-3){1'b0}}, round_up};
        r_carry  = m_sum[MW-3];
        r_hidden = r_carry | m_sum[MW-4];
        r_frac   = r_carry ? m_sum[MANTIS_SIZE:1] : m_sum[MANTIS_SIZE-1:0];
        r_exp    = r_carry ? e_inc : e_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            m_q            <= '0;
            e_q            <= '0;
            sign_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_float_q    <= '0;
            out_type_q     <= T_ZERO;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.in_sign;
                        m_q    <= bus.in_mantis;
                        e_q    <= bus.in_exp;
                        case (bus.in_type)
                            T_SUB, T_NORM: state_q <= S_NORM;
                            T_ZERO: begin
                                out_float_q    <= {bus.in_sign, EXP_ZERO, FRAC_ZERO};
                                out_type_q     <= T_ZERO;
                                out_inexact_q  <= 1'b0;
                                out_overflow_q <= 1'b0;
                                out_valid_q    <= 1'b1;
                                state_q        <= S_DONE;
                            end
                            T_INF: begin
                                out_float_q    <= {bus.in_sign, EXP_ONES, FRAC_ZERO};
                                out_type_q     <= T_INF;
                                out_inexact_q  <= 1'b0;
                                out_overflow_q <= 1'b0;
                                out_valid_q    <= 1'b1;
                                state_q        <= S_DONE;
                            end
                            default: begin
                                out_float_q    <= {bus.in_sign, EXP_ONES, FRAC_QNAN};
                                out_type_q     <= T_NAN;
                                out_inexact_q  <= 1'b0;
                                out_overflow_q <= 1'b0;
                                out_valid_q    <= 1'b1;
                                state_q        <= S_DONE;
                            end
                        endcase
                    end
                end
                S_NORM: begin
                    if (m_q == '0) begin
                        out_float_q    <= {sign_q, EXP_ZERO, FRAC_ZERO};
                        out_type_q     <= T_ZERO;
                        out_inexact_q  <= 1'b0;
                        out_overflow_q <= 1'b0;
                        out_valid_q    <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (m_q[MW-1]) begin
                        m_q <= m_shr;
                        e_q <= e_inc;
                    end else if (!m_q[MW-2] && (e_q > E_ONE)) begin
                        m_q <= m_q << 1;
                        e_q <= e_dec;
                    end else if (e_q < E_ONE) begin
                        state_q <= S_DENORM;
                    end else begin
                        state_q <= S_ROUND;
                    end
                end
                S_DENORM: begin
                    // Once only sticky remains, further shifting changes nothing.
                    m_q <= m_shr;
                    if ((e_inc == E_ONE) || (m_shr[MW-1:1] == '0)) begin
                        e_q     <= E_ONE;
                        state_q <= S_ROUND;
                    end else begin
                        e_q <= e_inc;
                    end
                end
                S_ROUND: begin
                    out_inexact_q <= m_q[1] | m_q[0];
                    out_valid_q   <= 1'b1;
                    state_q       <= S_DONE;
                    if (r_exp >= E_MAX) begin
                        out_float_q    <= {sign_q, EXP_ONES, FRAC_ZERO};
                        out_type_q     <= T_INF;
                        out_overflow_q <= 1'b1;
                    end else if (!r_hidden) begin
                        out_float_q    <= {sign_q, EXP_ZERO, r_frac};
                        out_type_q     <= (r_frac == FRAC_ZERO) ? T_ZERO : T_SUB;
                        out_overflow_q <= 1'b0;
                    end else begin
                        out_float_q    <= {sign_q, r_exp[EXP_SIZE-1:0], r_frac};
                        out_type_q     <= T_NORM;
                        out_overflow_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_float    = out_float_q;
    assign bus.out_type     = out_type_q;
    assign bus.out_inexact  = out_inexact_q;
    assign bus.out_overflow = out_overflow_q;
endmodule

// File: tb/tb_fp_pack.sv
// Directed bench for fp_pack (EXP_SIZE=8, MANTIS_SIZE=23) with hand-computed expected results.
module tb_fp_pack;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fp_pack_if bus ();

    fp_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [26:0] M_ONE = 27'h200_0000;  // 1.0
    localparam logic [26:0] M_TWO = 27'h400_0000;  // 2.0

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [2:0] t, input int ex,
                          input logic [26:0] mt, input int hold, input int exp_lat,
                          input logic [31:0] exp_f, input logic [2:0] exp_t,
                          input logic exp_ix, input logic exp_ov);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_sign   = s;
        bus.in_type   = t;
        bus.in_exp    = 10'(ex);
        bus.in_mantis = mt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op %s: float=%h type=%b inexact=%b overflow=%b latency=%0d",
                 tag, bus.out_float, bus.out_type, bus.out_inexact, bus.out_overflow, lat);
        chk({tag, ".valid"},    32'(bus.out_valid),    32'd1);
        chk({tag, ".latency"},  32'(lat),              32'(exp_lat));
        chk({tag, ".float"},    bus.out_float,         exp_f);
        chk({tag, ".type"},     32'(bus.out_type),     32'(exp_t));
        chk({tag, ".inexact"},  32'(bus.out_inexact),  32'(exp_ix));
        chk({tag, ".overflow"}, 32'(bus.out_overflow), 32'(exp_ov));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"},    32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_float"},    bus.out_float,      exp_f);
            chk({tag, ".hold_type"},     32'(bus.out_type),  32'(exp_t));
            chk({tag, ".hold_in_ready"}, 32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".drop_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_type   = 3'b000;
        bus.in_exp    = '0;
        bus.in_mantis = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.in_ready",  32'(bus.in_ready),     32'd1);
        chk("reset.out_valid", 32'(bus.out_valid),    32'd0);
        chk("reset.float",     bus.out_float,         32'h0000_0000);
        chk("reset.type",      32'(bus.out_type),     32'd0);
        chk("reset.inexact",   32'(bus.out_inexact),  32'd0);
        chk("reset.overflow",  32'(bus.out_overflow), 32'd0);

        // Specials
        run_op("inf_neg",  1'b1, 3'b001, 0, '0, 0, 1, 32'hFF80_0000, 3'b001, 1'b0, 1'b0);
        run_op("nan_pos",  1'b0, 3'b100, 0, '0, 0, 1, 32'h7FC0_0000, 3'b100, 1'b0, 1'b0);
        run_op("type110",  1'b0, 3'b110, 5, M_ONE, 0, 1, 32'h7FC0_0000, 3'b100, 1'b0, 1'b0);
        run_op("zero_neg", 1'b1, 3'b000, 127, M_ONE, 0, 1, 32'h8000_0000, 3'b000, 1'b0, 1'b0);

        // Normal, carry-in and left normalisation
        run_op("one",      1'b0, 3'b011, 127, M_ONE, 0, 3, 32'h3F80_0000, 3'b011, 1'b0, 1'b0);
        run_op("two_rsh",  1'b0, 3'b011, 127, M_TWO, 0, 4, 32'h4000_0000, 3'b011, 1'b0, 1'b0);
        run_op("two_lsh",  1'b0, 3'b011, 130, 27'h080_0000, 0, 5, 32'h4000_0000, 3'b011, 1'b0, 1'b0);
        run_op("neg_m0",   1'b1, 3'b011, 100, '0, 0, 2, 32'h8000_0000, 3'b000, 1'b0, 1'b0);

        // Tie-to-even
        run_op("tie_even", 1'b0, 3'b011, 127, M_ONE | 27'd2, 0, 3, 32'h3F80_0000, 3'b011, 1'b1, 1'b0);
        run_op("tie_odd",  1'b0, 3'b011, 127, M_ONE | 27'd6, 0, 3, 32'h3F80_0002, 3'b011, 1'b1, 1'b0);
        run_op("g_sticky", 1'b0, 3'b011, 127, M_ONE | 27'd3, 0, 3, 32'h3F80_0001, 3'b011, 1'b1, 1'b0);

        // Overflow through rounding carry
        run_op("overflow", 1'b0, 3'b011, 254, 27'h3FF_FFFE, 0, 3, 32'h7F80_0000, 3'b001, 1'b1, 1'b1);

        // Subnormal and underflow to zero
        run_op("subnorm",  1'b0, 3'b010, 0, M_ONE, 0, 4, 32'h0040_0000, 3'b010, 1'b0, 1'b0);
        run_op("underflw", 1'b0, 3'b010, -40, M_ONE, 0, 28, 32'h0000_0000, 3'b000, 1'b1, 1'b0);

        // Backpressure: result held for 5 cycles
        run_op("backpres", 1'b1, 3'b011, 127, M_ONE, 5, 3, 32'hBF80_0000, 3'b011, 1'b0, 1'b0);

        // Reset while normalising abandons the operation
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sign   = 1'b0;
        bus.in_type   = 3'b011;
        bus.in_exp    = 10'd130;
        bus.in_mantis = 27'h010_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("op rst_norm: out_valid=%b in_ready=%b float=%h",
                 bus.out_valid, bus.in_ready, bus.out_float);
        chk("rst_norm.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_norm.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_norm.float",     bus.out_float,      32'h0000_0000);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("rst_norm.no_output", 32'(seen), 32'd0);

        run_op("after_rst", 1'b0, 3'b011, 128, M_ONE, 0, 3, 32'h4000_0000, 3'b011, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
